// File: rtl/snake_head_stepper.sv
// snake_head_stepper: steps the snake head once per game tick and runs the IDLE/RUN/DEAD control; define SNAKE_WRAP_EN to wrap at walls instead of dying
module snake_head_stepper #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int START_X  = 16,
  parameter int START_Y  = 12,
  parameter int STEP_DIV = 5000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    key,
  input  logic          start,
  input  logic          pause,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic          head_valid,
  output logic          running,
  output logic          game_over
);
  localparam int CW = $clog2(STEP_DIV);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] dx, dy, kx, ky, ex, ey;
  logic kv, step, hit, mv, restart, lo_x, hi_x, lo_y, hi_y;
  logic [XW-1:0] sx, nx;
  logic [YW-1:0] sy, ny;
  // decode the numpad code into per-axis steps: 2'b11 is -1, 2'b01 is +1
  always_comb begin
    kx = 2'b00;
    ky = 2'b00;
    kv = 1'b1;
    case (key)
      8'h38: ky = 2'b11;
      8'h32: ky = 2'b01;
      8'h34: kx = 2'b11;
      8'h36: kx = 2'b01;
      8'h37: begin kx = 2'b11; ky = 2'b11; end
      8'h39: begin kx = 2'b01; ky = 2'b11; end
      8'h31: begin kx = 2'b11; ky = 2'b01; end
      8'h33: begin kx = 2'b01; ky = 2'b01; end
      default: kv = 1'b0;
    endcase
  end
  // candidate head position, wall detection, counter and next state
  always_comb begin
    ex = kv ? kx : dx;
    ey = kv ? ky : dy;
    step = state == RUN && !pause && cnt == CW'(STEP_DIV - 1);
    lo_x = ex == 2'b11 && head_x == '0;
    hi_x = ex == 2'b01 && head_x == XW'(GRID_W - 1);
    lo_y = ey == 2'b11 && head_y == '0;
    hi_y = ey == 2'b01 && head_y == YW'(GRID_H - 1);
    sx = head_x + {{(XW-2){ex[1]}}, ex};
    sy = head_y + {{(YW-2){ey[1]}}, ey};
`ifdef SNAKE_WRAP_EN
    nx = lo_x ? XW'(GRID_W - 1) : hi_x ? '0 : sx;
    ny = lo_y ? YW'(GRID_H - 1) : hi_y ? '0 : sy;
    hit = 1'b0;
`else
    nx = sx;
    ny = sy;
    hit = lo_x | hi_x | lo_y | hi_y;
`endif
    mv = step && !hit;
    restart = state == DEAD && start;
    cnt_nxt = state == IDLE ? '0 : (state == RUN && !pause) ? (step ? '0 : cnt + CW'(1)) : cnt;
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (step && hit ? DEAD : RUN) :
                (start ? IDLE : DEAD);
  end
  // state, tick counter, latched direction and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dx         <= 2'b11;
      dy         <= 2'b00;
      head_x     <= XW'(START_X);
      head_y     <= YW'(START_Y);
      head_valid <= 1'b0;
      running    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      head_valid <= mv;
      running    <= state_nxt == RUN;
      game_over  <= state_nxt == DEAD;
      if (step) begin
        dx <= ex;
        dy <= ey;
      end
      if (restart) begin
        head_x <= XW'(START_X);
        head_y <= YW'(START_Y);
      end else if (mv) begin
        head_x <= nx;
        head_y <= ny;
      end
    end
  end
endmodule

// File: tb/tb_snake_head_stepper.sv
// tb_snake_head_stepper: directed and randomized checks of snake_head_stepper against a behavioural model
module tb_snake_head_stepper;
  localparam int GW = 32, GH = 24, SD = 4;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, pause = 1'b0;
  logic [7:0] key = 8'h00;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic head_valid, running, game_over;
  int pass_cnt = 0, total = 0;
  bit chk_en = 1'b0;
  int mx = 16, my = 12, mdx = -1, mdy = 0, tick_n = 0;
  bit alive = 1'b0, dead = 1'b0, mvalid = 1'b0;

  snake_head_stepper #(.STEP_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .start(start), .pause(pause),
    .head_x(head_x), .head_y(head_y), .head_valid(head_valid),
    .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  function automatic bit dec(input logic [7:0] k, output int dx, output int dy);
    dx = 0;
    dy = 0;
    case (k)
      8'h38: dy = -1;
      8'h32: dy = 1;
      8'h34: dx = -1;
      8'h36: dx = 1;
      8'h37: begin dx = -1; dy = -1; end
      8'h39: begin dx = 1;  dy = -1; end
      8'h31: begin dx = -1; dy = 1;  end
      8'h33: begin dx = 1;  dy = 1;  end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // behavioural game model: idle / alive / dead with an integer tick phase
  initial forever begin
    int dx, dy, tx, ty;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mx = 16; my = 12; mdx = -1; mdy = 0; tick_n = 0;
      alive = 1'b0; dead = 1'b0; mvalid = 1'b0;
    end else begin
      mvalid = 1'b0;
      if (dead) begin
        if (start) begin dead = 1'b0; mx = 16; my = 12; tick_n = 0; end
      end else if (!alive) begin
        if (start) begin alive = 1'b1; tick_n = 0; end
      end else if (!pause) begin
        if (tick_n < SD - 1) tick_n++;
        else begin
          tick_n = 0;
          if (dec(key, dx, dy)) begin mdx = dx; mdy = dy; end
          tx = mx + mdx;
          ty = my + mdy;
          if (WRAP) begin
            mx = (tx + GW) % GW; my = (ty + GH) % GH; mvalid = 1'b1;
          end else if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
            mx = tx; my = ty; mvalid = 1'b1;
          end else begin
            alive = 1'b0; dead = 1'b1;
          end
        end
      end
    end
  end

  // compare every output against the model away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("head_x", head_x, mx);
      chk("head_y", head_y, my);
      chk("head_valid", head_valid, mvalid);
      chk("running", running, alive);
      chk("game_over", game_over, dead);
    end
  end

  initial begin
    int r;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_x", head_x, 16);
    chk("rst_y", head_y, 12);
    chk("rst_valid", head_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_over", game_over, 0);
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    key = 8'h36; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("run_flag", running, 1);
    tick(3);
    chk("right_before", head_x, 16);
    tick(1);
    chk("right_1", head_x, 17);
    chk("right_1_valid", head_valid, 1);
    tick(4);
    chk("right_2", head_x, 18);
    chk("right_2_y", head_y, 12);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_x", head_x, 16);
    chk("midrun_rst_run", running, 0);
    tick(1);
    rst_n = 1'b1;
    key = 8'h34; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16 * SD);
    chk("left_edge_x", head_x, 0);
    tick(SD);
    if (WRAP) begin
      chk("wrap_x", head_x, 31);
      chk("wrap_over", game_over, 0);
    end else begin
      chk("wall_over", game_over, 1);
      chk("wall_x", head_x, 0);
      chk("wall_valid", head_valid, 0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("restart_x", head_x, 16);
      chk("restart_over", game_over, 0);
      chk("restart_run", running, 0);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    key = 8'h39; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(SD);
    chk("diag_x", head_x, 17);
    chk("diag_y", head_y, 11);
    key = 8'h35;
    tick(SD);
    chk("keep_x", head_x, 18);
    chk("keep_y", head_y, 10);
    tick(2);
    pause = 1'b1;
    tick(10);
    chk("pause_x", head_x, 18);
    chk("pause_run", running, 1);
    pause = 1'b0;
    tick(1);
    chk("resume_wait", head_valid, 0);
    tick(1);
    chk("resume_x", head_x, 19);
    chk("resume_y", head_y, 9);
    chk("resume_valid", head_valid, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      key = (r < 9) ? 8'(8'h31 + r) : 8'($urandom_range(0, 255));
      start = $urandom_range(0, 99) < 4;
      pause = $urandom_range(0, 99) < 15;
      rst_n = $urandom_range(0, 999) != 0;
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
